exec_commit_stage: RTL and testbench

- Sits directly downstream of the combinational ALU; registers its result into the EX/MEM pipeline latch.
- Owns the architectural SZCV flag register; the registered flags drive the ALU S_in/Z_in/C_in/V_in.
- Turns ALU flush into a one-cycle PC redirect plus squash of younger in-flight instructions.
- Latches HLT and freezes the pipeline.

---
 rtl/isa_pkg.sv | 34 +++
 rtl/commit_decode.sv | 34 +++
 rtl/exec_commit_stage.sv | 132 +++++++++++++
 tb/tb_exec_commit_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA encodings used by the commit stage and its decoder.
package isa_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP1_LD     = 2'b00,
        OP1_ST     = 2'b01,
        OP1_IMM_BR = 2'b10,
        OP1_ALU    = 2'b11
    } op1_e;

    typedef enum logic [2:0] {
        OP2_LI   = 3'b000,
        OP2_ADDI = 3'b001,
        OP2_SUBI = 3'b010,
        OP2_B    = 3'b100,
        OP2_JR   = 3'b101,
        OP2_JAL  = 3'b110,
        OP2_BCC  = 3'b111
    } op2_e;

    localparam logic [3:0] OPC_ADD = 4'd0;
    localparam logic [3:0] OPC_CMP = 4'd5;
    localparam logic [3:0] OPC_HLT = 4'd15;

    // One bit per ALU opcode: set where the opcode writes a register (0-4, 6, 8-12).
    localparam logic [15:0] OPC_WRITES_MASK = 16'h1F5F;

    function automatic logic opc_writes(input logic [3:0] opc);
        return OPC_WRITES_MASK[opc];
    endfunction

endpackage

// File: rtl/commit_decode.sv
// Combinational decode of instruction class/sub-op into commit enables.
module commit_decode
    import isa_pkg::*;
(
    input  logic [1:0] op1_i,
    input  logic [2:0] op2_i,
    input  logic [3:0] opcode_i,
    output logic       wen_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       z_override_o
);

    always_comb begin
        wen_o        = 1'b0;
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        z_override_o = 1'b0;
        case (op1_i)
            OP1_ALU: wen_o = opc_writes(opcode_i);
            OP1_LD: begin
                mem_rd_o = 1'b1;
                wen_o    = 1'b1;
            end
            OP1_ST: mem_wr_o = 1'b1;
            default: begin
                wen_o        = (op2_i == OP2_LI) || (op2_i == OP2_ADDI) || (op2_i == OP2_SUBI);
                // SUBI derives Z from its own result rather than the ALU's Z output.
                z_override_o = (op2_i == OP2_SUBI);
            end
        endcase
    end

endmodule

// File: rtl/exec_commit_stage.sv
// EX/MEM latch with architectural flags, branch redirect/squash and sticky halt.
module exec_commit_stage
    import isa_pkg::*;
#(
    parameter int DATA_W       = isa_pkg::DATA_W,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_s,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              alu_hlt,
    input  logic              alu_flush,
    input  logic [1:0]        op1,
    input  logic [2:0]        op2,
    input  logic [3:0]        opcode,
    input  logic [2:0]        rd_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              flag_s,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              out_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_store_data,
    output logic [2:0]        out_rd,
    output logic              out_wen,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              halted
);

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_DEPTH);

    logic [3:0]        flags_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_store_data_q;
    logic [2:0]        out_rd_q;
    logic              out_wen_q;
    logic              out_mem_rd_q;
    logic              out_mem_wr_q;
    logic              redirect_valid_q;
    logic [DATA_W-1:0] redirect_pc_q;
    logic              halted_q;
    logic [2:0]        sq_cnt_q;

    logic dec_wen, dec_mem_rd, dec_mem_wr, dec_z_override;
    logic accept, live, drop, kill, flag_z_d;

    commit_decode u_decode (
        .op1_i        (op1),
        .op2_i        (op2),
        .opcode_i     (opcode),
        .wen_o        (dec_wen),
        .mem_rd_o     (dec_mem_rd),
        .mem_wr_o     (dec_mem_wr),
        .z_override_o (dec_z_override)
    );

    assign in_ready = !halted_q && (!out_valid_q || mem_ready);
    assign accept   = in_valid && in_ready;
    assign live     = accept && (sq_cnt_q == 3'd0);
    assign drop     = accept && (sq_cnt_q != 3'd0);
    // Redirecting or halting beats still occupy the latch but must not commit side effects.
    assign kill     = alu_flush || alu_hlt;
    assign flag_z_d = dec_z_override ? (alu_out == '0) : alu_z;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q          <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_store_data_q <= '0;
            out_rd_q         <= '0;
            out_wen_q        <= 1'b0;
            out_mem_rd_q     <= 1'b0;
            out_mem_wr_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            halted_q         <= 1'b0;
            sq_cnt_q         <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            if (live) begin
                out_valid_q      <= 1'b1;
                out_data_q       <= alu_out;
                out_store_data_q <= store_data;
                out_rd_q         <= rd_addr;
                out_wen_q        <= dec_wen && !kill;
                out_mem_rd_q     <= dec_mem_rd && !kill;
                out_mem_wr_q     <= dec_mem_wr && !kill;
                flags_q          <= {alu_s, flag_z_d, alu_c, alu_v};
                if (alu_hlt) begin
                    halted_q <= 1'b1;
                end else if (alu_flush) begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= alu_out;
                    sq_cnt_q         <= SQ_LOAD;
                end
            end else begin
                if (drop) begin
                    sq_cnt_q <= sq_cnt_q - 3'd1;
                end
                if (mem_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign {flag_s, flag_z, flag_c, flag_v} = flags_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_store_data = out_store_data_q;
    assign out_rd         = out_rd_q;
    assign out_wen        = out_wen_q;
    assign out_mem_rd     = out_mem_rd_q;
    assign out_mem_wr     = out_mem_wr_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_exec_commit_stage.sv
// Directed bench for exec_commit_stage: per-cycle model compare plus literal spot checks.
module tb_exec_commit_stage;

    localparam int DW = 16;
    localparam int SQ = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] alu_out = '0;
    logic          alu_s = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
    logic          alu_hlt = 1'b0, alu_flush = 1'b0;
    logic [1:0]    op1 = '0;
    logic [2:0]    op2 = '0;
    logic [3:0]    opcode = '0;
    logic [2:0]    rd_addr = '0;
    logic [DW-1:0] store_data = '0;
    logic          flag_s, flag_z, flag_c, flag_v;
    logic          out_valid;
    logic          mem_ready = 1'b1;
    logic [DW-1:0] out_data, out_store_data, redirect_pc;
    logic [2:0]    out_rd;
    logic          out_wen, out_mem_rd, out_mem_wr, redirect_valid, halted;

    int checks = 0;
    int errors = 0;

    exec_commit_stage #(.DATA_W(DW), .SQUASH_DEPTH(SQ)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .alu_hlt(alu_hlt), .alu_flush(alu_flush), .op1(op1), .op2(op2), .opcode(opcode),
        .rd_addr(rd_addr), .store_data(store_data),
        .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .out_valid(out_valid), .mem_ready(mem_ready), .out_data(out_data),
        .out_store_data(out_store_data), .out_rd(out_rd), .out_wen(out_wen),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0]   writes_tbl = 16'b0001_1111_0101_1111;
    logic          m_valid, m_wen, m_mrd, m_mwr, m_redir, m_halted;
    logic          m_s, m_z, m_c, m_v;
    logic [DW-1:0] m_data, m_sd, m_pc;
    logic [2:0]    m_rd;
    int            m_sq;

    function automatic logic writes_reg(input logic [1:0] c, input logic [2:0] s, input logic [3:0] opc);
        if (c == 2'b11) return writes_tbl[opc];
        if (c == 2'b00) return 1'b1;
        if (c == 2'b01) return 1'b0;
        return (s == 3'd0) || (s == 3'd1) || (s == 3'd2);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 0; m_wen <= 0; m_mrd <= 0; m_mwr <= 0; m_redir <= 0; m_halted <= 0;
            m_s <= 0; m_z <= 0; m_c <= 0; m_v <= 0;
            m_data <= '0; m_sd <= '0; m_pc <= '0; m_rd <= '0; m_sq <= 0;
        end else begin
            m_redir <= 0;
            if (in_valid && !m_halted && (!m_valid || mem_ready)) begin
                if (m_sq > 0) begin
                    m_sq    <= m_sq - 1;
                    m_valid <= 0;
                end else begin
                    m_valid <= 1;
                    m_data  <= alu_out;
                    m_sd    <= store_data;
                    m_rd    <= rd_addr;
                    m_wen   <= !(alu_flush || alu_hlt) && writes_reg(op1, op2, opcode);
                    m_mrd   <= !(alu_flush || alu_hlt) && (op1 == 2'b00);
                    m_mwr   <= !(alu_flush || alu_hlt) && (op1 == 2'b01);
                    m_s <= alu_s; m_c <= alu_c; m_v <= alu_v;
                    m_z <= (op1 == 2'b10 && op2 == 3'b010) ? (alu_out == 0) : alu_z;
                    if (alu_hlt) m_halted <= 1;
                    else if (alu_flush) begin
                        m_redir <= 1;
                        m_pc    <= alu_out;
                        m_sq    <= SQ;
                    end
                end
            end else if (mem_ready) begin
                m_valid <= 0;
            end
        end
    end

    // Compare every cycle, 1ns after the edge (driver acts at +2ns).
    always @(posedge clk) begin
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_halted && (!m_valid || mem_ready)));
        check("flags", 32'({flag_s, flag_z, flag_c, flag_v}), 32'({m_s, m_z, m_c, m_v}));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halted));
        check("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        check("redirect_pc", 32'(redirect_pc), 32'(m_pc));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_store_data", 32'(out_store_data), 32'(m_sd));
            check("out_rd", 32'(out_rd), 32'(m_rd));
            check("enables", 32'({out_wen, out_mem_rd, out_mem_wr}), 32'({m_wen, m_mrd, m_mwr}));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [1:0] c, input logic [2:0] s, input logic [3:0] opc,
                        input logic [DW-1:0] res, input logic [3:0] szcv,
                        input logic hlt, input logic fl);
        in_valid = 1'b1;
        op1 = c; op2 = s; opcode = opc; alu_out = res;
        {alu_s, alu_z, alu_c, alu_v} = szcv;
        alu_hlt = hlt; alu_flush = fl;
        rd_addr = rd_addr + 3'd1;
        store_data = res ^ 16'hA5A5;
        $display("beat op1=%b op2=%b opc=%0d alu_out=%h szcv=%b hlt=%b flush=%b", c, s, opc, res, szcv, hlt, fl);
    endtask

    task automatic idle();
        in_valid = 1'b0; alu_hlt = 1'b0; alu_flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst flags", 32'({flag_s, flag_z, flag_c, flag_v}), 0);
        check("rst halted", 32'(halted), 0);
        check("rst in_ready", 32'(in_ready), 1);

        // ADD with zero result
        beat(2'b11, 3'd0, 4'd0, 16'h0000, 4'b0100, 0, 0); tick();
        check("add out_valid", 32'(out_valid), 1);
        check("add out_wen", 32'(out_wen), 1);
        check("add flag_z", 32'(flag_z), 1);
        check("add flag_s", 32'(flag_s), 0);

        // SUBI: Z comes from the result, not alu_z
        beat(2'b10, 3'b010, 4'd0, 16'h0000, 4'b0100, 0, 0); tick();
        check("subi0 flag_z", 32'(flag_z), 1);
        beat(2'b10, 3'b010, 4'd0, 16'h0005, 4'b0100, 0, 0); tick();
        check("subi5 flag_z", 32'(flag_z), 0);

        // load and store
        beat(2'b00, 3'd0, 4'd0, 16'h0100, 4'b0000, 0, 0); tick();
        check("ld enables", 32'({out_wen, out_mem_rd, out_mem_wr}), 32'b110);
        beat(2'b01, 3'd0, 4'd0, 16'h1B4A, 4'b0000, 0, 0); tick();
        check("st enables", 32'({out_wen, out_mem_rd, out_mem_wr}), 32'b001);
        check("st data", 32'(out_store_data), 32'h0000BEEF);

        // taken branch then three back-to-back beats
        beat(2'b10, 3'b100, 4'd0, 16'h0040, 4'b0000, 0, 1); tick();
        check("br redirect_valid", 32'(redirect_valid), 1);
        check("br redirect_pc", 32'(redirect_pc), 32'h40);
        check("br out_wen", 32'(out_wen), 0);
        beat(2'b11, 3'd0, 4'd0, 16'h1111, 4'b1000, 0, 0); tick();
        check("sq1 redirect_valid", 32'(redirect_valid), 0);
        check("sq1 flag_s", 32'(flag_s), 0);
        beat(2'b11, 3'd0, 4'd0, 16'h1111, 4'b1000, 0, 0); tick();
        check("sq2 out_valid", 32'(out_valid), 0);
        beat(2'b11, 3'd0, 4'd0, 16'h2222, 4'b1000, 0, 0); tick();
        check("sq3 flag_s", 32'(flag_s), 1);
        check("sq3 out_data", 32'(out_data), 32'h2222);

        // backpressure
        mem_ready = 1'b0;
        beat(2'b11, 3'd0, 4'd1, 16'h3333, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp in_ready", 32'(in_ready), 0);
            check("bp out_data", 32'(out_data), 32'h2222);
        end
        mem_ready = 1'b1;
        tick();
        check("bp accept", 32'(out_data), 32'h3333);

        // ALU opcode write table (halt excluded) and op2 sweep
        for (int k = 0; k < 15; k++) begin
            beat(2'b11, 3'd0, 4'(k), 16'(k), 4'(k), 0, 0); tick();
            if (k == 5 || k == 7 || k == 13 || k == 12)
                check("opc wen", 32'(out_wen), (k == 12) ? 1 : 0);
        end
        for (int k = 0; k < 8; k++) begin
            beat(2'b10, 3'(k), 4'd0, 16'(k + 1), 4'b0001, 0, 0); tick();
        end

        // halt
        beat(2'b11, 3'd0, 4'd15, 16'h00FF, 4'b0010, 1, 0); tick();
        check("hlt halted", 32'(halted), 1);
        check("hlt in_ready", 32'(in_ready), 0);
        check("hlt out_wen", 32'(out_wen), 0);
        beat(2'b11, 3'd0, 4'd0, 16'h4444, 4'b1000, 0, 0); tick();
        check("hlt drained", 32'(out_valid), 0);
        check("hlt flag_c", 32'(flag_c), 1);
        tick();
        do_reset();
        check("post-rst halted", 32'(halted), 0);
        check("post-rst flags", 32'({flag_s, flag_z, flag_c, flag_v}), 0);

        // flush and halt together
        beat(2'b10, 3'b100, 4'd0, 16'h0080, 4'b0000, 1, 1); tick();
        check("fh halted", 32'(halted), 1);
        check("fh redirect_valid", 32'(redirect_valid), 0);
        do_reset();

        // halt during squash is ignored
        beat(2'b10, 3'b100, 4'd0, 16'h0060, 4'b0000, 0, 1); tick();
        beat(2'b11, 3'd0, 4'd15, 16'h0000, 4'b0000, 1, 0); tick();
        check("sqhlt halted", 32'(halted), 0);
        beat(2'b11, 3'd0, 4'd0, 16'h5555, 4'b0000, 0, 1); tick();
        check("sqflush redirect", 32'(redirect_valid), 0);
        beat(2'b11, 3'd0, 4'd0, 16'h7777, 4'b0000, 0, 0); tick();
        check("post-sq out_data", 32'(out_data), 32'h7777);

        // reset mid-squash discards the pending squash
        beat(2'b10, 3'b100, 4'd0, 16'h0090, 4'b0000, 0, 1); tick();
        do_reset();
        beat(2'b11, 3'd0, 4'd0, 16'h0ABC, 4'b0000, 0, 0); tick();
        check("rst-sq out_valid", 32'(out_valid), 1);
        check("rst-sq out_data", 32'(out_data), 32'h0ABC);
        idle(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
